// File: rtl/uart_frame_gen.sv
// UART frame generator: byte FIFO feeding a start/data/parity/stop serializer.
// Baud divider, parity mode and stop-bit count are latched with each byte as it is popped.
module uart_frame_gen #(
  parameter int unsigned DIV_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_WIDTH  = 5
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic [1:0]           cfg_parity_i,
  input  logic                 cfg_stop2_i,
  input  logic                 wr_en_i,
  input  logic [7:0]           wr_data_i,
  input  logic                 ovf_clr_i,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 frame_done_o,
  output logic                 ovf_o
);

  localparam int unsigned          PW      = $clog2(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wptr_q;
  logic [PW-1:0]        rptr_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 ovf_q;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [7:0]           head;

  // Serializer state
  state_e               state_q, state_d;
  logic [7:0]           data_q, data_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 par_en_q, par_en_d;
  logic                 par_odd_q, par_odd_d;
  logic                 stop2_q, stop2_d;
  logic [DIV_WIDTH-1:0] baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic                 tx_q, tx_d;
  logic                 bit_end;
  logic                 frame_done;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  // full is the pre-edge value, so a write into a full FIFO is dropped even on a pop edge
  assign push  = wr_en_i && !full;
  assign head  = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_WIDTH'(1);
        2'b01:   count_q <= count_q - CNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
      if (ovf_clr_i) begin
        ovf_q <= 1'b0;
      end else if (wr_en_i && full) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign bit_end = (baud_q == div_q - DIV_WIDTH'(1));

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    div_d      = div_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop2_d    = stop2_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    pop        = 1'b0;
    frame_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        pop = !empty;
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + DIV_WIDTH'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            stop_d  = 1'b0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + DIV_WIDTH'(1);
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          stop_d  = 1'b0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + DIV_WIDTH'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (!stop2_q || stop_q) begin
            frame_done = 1'b1;
            pop        = !empty;
            state_d    = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + DIV_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pop from IDLE or from the final stop cycle starts the next frame with fresh config
    if (pop) begin
      state_d   = S_START;
      data_d    = head;
      div_d     = (cfg_div_i == '0) ? DIV_WIDTH'(1) : cfg_div_i;
      par_en_d  = (cfg_parity_i == 2'b01) || (cfg_parity_i == 2'b10);
      par_odd_d = (cfg_parity_i == 2'b10);
      stop2_d   = cfg_stop2_i;
      baud_d    = '0;
      bit_d     = '0;
      stop_d    = 1'b0;
    end

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_d[bit_d];
      S_PARITY: tx_d = par_odd_d ? ~^data_d : ^data_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      div_q     <= DIV_WIDTH'(1);
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      baud_q    <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      div_q     <= div_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      stop2_q   <= stop2_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      tx_q      <= tx_d;
    end
  end

  assign tx_o         = tx_q;
  assign busy_o       = (state_q != S_IDLE);
  assign full_o       = full;
  assign empty_o      = empty;
  assign count_o      = count_q;
  assign frame_done_o = frame_done;
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_uart_frame_gen.sv
// Directed bench for uart_frame_gen: table of single-frame vectors plus hand-written
// back-to-back, FIFO-full/overflow, mid-frame divider change and mid-frame reset sequences.
module tb_uart_frame_gen;

  logic        clk = 1'b0;
  logic        arst;
  logic [31:0] cfg_div;
  logic [1:0]  cfg_par;
  logic        cfg_stop2;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        ovf_clr;
  logic        tx_o, busy_o, full_o, empty_o, frame_done_o, ovf_o;
  logic [4:0]  count_o;

  uart_frame_gen #(.DIV_WIDTH(32), .FIFO_DEPTH(16), .CNT_WIDTH(5)) dut (
    .clk_i        (clk),
    .arst_i       (arst),
    .cfg_div_i    (cfg_div),
    .cfg_parity_i (cfg_par),
    .cfg_stop2_i  (cfg_stop2),
    .wr_en_i      (wr_en),
    .wr_data_i    (wr_data),
    .ovf_clr_i    (ovf_clr),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .count_o      (count_o),
    .frame_done_o (frame_done_o),
    .ovf_o        (ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] div;
    logic [1:0]  par;
    logic        stop2;
    logic [7:0]  data;
    int          per;   // effective bit period
    logic [11:0] bits;  // serial bits, index 0 = start bit
    int          len;   // frame length in cycles
  } vec_t;

  vec_t vecs[8];
  int   checks   = 0;
  int   failures = 0;
  int   wave_err, done_err, busy_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_errs();
    wave_err = 0;
    done_err = 0;
    busy_err = 0;
  endtask

  task automatic chk_errs(input string tag);
    chk({tag, "_wave_errs"}, wave_err, 0);
    chk({tag, "_done_errs"}, done_err, 0);
    chk({tag, "_busy_errs"}, busy_err, 0);
  endtask

  task automatic tick(input logic etx, input logic edone, input logic ebusy);
    @(negedge clk);
    if (tx_o !== etx) wave_err++;
    if (frame_done_o !== edone) done_err++;
    if (busy_o !== ebusy) busy_err++;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    cfg_div   = v.div;
    cfg_par   = v.par;
    cfg_stop2 = v.stop2;
    wr_en     = 1'b1;
    wr_data   = v.data;
    @(negedge clk);
    wr_en = 1'b0;
    chk({tag, "_prepop_tx"}, tx_o, 1);
    chk({tag, "_prepop_cnt"}, count_o, 1);
    clr_errs();
    for (int c = 1; c <= v.len; c++) tick(v.bits[(c-1)/v.per], c == v.len, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    chk_errs(tag);
    chk({tag, "_cnt_end"}, count_o, 0);
  endtask

  initial begin
    logic [29:0] stream;
    logic [9:0]  fr;

    vecs[0] = '{32'd4, 2'b00, 1'b0, 8'h55, 4, 12'h2AA, 40};
    vecs[1] = '{32'd3, 2'b01, 1'b0, 8'h07, 3, 12'h60E, 33};
    vecs[2] = '{32'd3, 2'b10, 1'b0, 8'h07, 3, 12'h40E, 33};
    vecs[3] = '{32'd3, 2'b01, 1'b1, 8'h07, 3, 12'hE0E, 36};
    vecs[4] = '{32'd0, 2'b00, 1'b0, 8'hFF, 1, 12'h3FE, 10};
    vecs[5] = '{32'd1, 2'b11, 1'b0, 8'h00, 1, 12'h200, 10};
    vecs[6] = '{32'd2, 2'b10, 1'b0, 8'h00, 2, 12'h600, 22};
    vecs[7] = '{32'd5, 2'b01, 1'b0, 8'h81, 5, 12'h502, 55};

    arst = 1'b1; cfg_div = 32'd4; cfg_par = 2'b00; cfg_stop2 = 1'b0;
    wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    chk("rst_tx", tx_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_done", frame_done_o, 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back frames, div=2: no idle gap, bytes in order
    cfg_div = 32'd2; cfg_par = 2'b00; cfg_stop2 = 1'b0;
    wr_en = 1'b1; wr_data = 8'hA1;
    @(negedge clk);
    wr_data = 8'hB2;
    stream = {10'h386, 10'h364, 10'h342};
    clr_errs();
    for (int c = 1; c <= 60; c++) begin
      tick(stream[(c-1)/2], (c % 20) == 0, 1'b1);
      if (c == 1) begin chk("b2b_cnt_c1", count_o, 1); wr_data = 8'hC3; end
      if (c == 2) begin chk("b2b_cnt_c2", count_o, 2); wr_en = 1'b0; end
      if (c == 21) chk("b2b_cnt_c21", count_o, 1);
      if (c == 41) chk("b2b_cnt_c41", count_o, 0);
    end
    tick(1'b1, 1'b0, 1'b0);
    chk_errs("b2b");

    // Stalled FSM: fill FIFO, overflow, clear priority, then divider change mid-frame
    cfg_div = 32'd1000;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
      @(negedge clk);
    end
    chk("fill_count", count_o, 16);
    chk("fill_full", full_o, 1);
    chk("fill_ovf", ovf_o, 0);
    wr_data = 8'hEE;
    @(negedge clk);
    wr_en = 1'b0;
    chk("ovf_set", ovf_o, 1);
    chk("ovf_count", count_o, 16);
    @(negedge clk);
    chk("ovf_sticky", ovf_o, 1);
    ovf_clr = 1'b1; wr_en = 1'b1; wr_data = 8'hEF;
    @(negedge clk);
    chk("ovf_clr_wins", ovf_o, 0);
    chk("ovf_clr_count", count_o, 16);
    ovf_clr = 1'b0; wr_en = 1'b0; cfg_div = 32'd1;
    clr_errs();
    fr = 10'h220;
    for (int c = 20; c <= 10000; c++) tick(fr[(c-1)/1000], c == 10000, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      fr = {1'b1, 8'h10 + 8'(k), 1'b0};
      for (int b = 0; b < 10; b++) begin
        tick(fr[b], b == 9, 1'b1);
        if (k == 1 && b == 0) chk("drain_cnt", count_o, 15);
      end
    end
    tick(1'b1, 1'b0, 1'b0);
    chk_errs("stall");
    chk("drain_empty", empty_o, 1);

    // Asynchronous reset in the middle of a data bit
    cfg_div = 32'd4; wr_en = 1'b1; wr_data = 8'h00;
    @(negedge clk);
    wr_data = 8'h5A;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_tx", tx_o, 0);
    chk("pre_rst_cnt", count_o, 1);
    arst = 1'b1;
    #1;
    chk("arst_tx", tx_o, 1);
    chk("arst_busy", busy_o, 0);
    chk("arst_cnt", count_o, 0);
    chk("arst_empty", empty_o, 1);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    run_vec(vecs[0], "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
